// File: rtl/echo_unit.sv
// ---------------------------------------------------------------------------
// echo_unit -- feedback echo effect on a 16-bit signed audio stream.
//
// A DEPTH-sample circular delay line (DEPTH = 2**ADDR_W) holds past outputs.
// Each accepted sample is mixed with the attenuated sample found at the write
// pointer. The mix goes to the output and is also written back to the delay
// line, which gives a decaying feedback echo. With enable low the block
// bypasses the mix: the input is passed through and stored in the delay line.
//
// Parameters
//   ADDR_W       log2 of delay-line depth
//   ATTEN_SHIFT  arithmetic right shift applied to the delayed sample
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   new_sample_in     one-cycle strobe, sample_in valid
//   sample_in         signed input sample
//   enable            1 = echo mixed in, 0 = bypass
//   clear             one-cycle request to zero the delay line
//   sample_out        signed processed sample (registered, held between strobes)
//   sample_out_valid  one-cycle strobe, two cycles after an accepted input
//   busy              high while the delay line is being zeroed
//
// Build option
//   ECHO_SATURATE_EN  when defined the mix is clamped to the 16-bit range,
//                     otherwise it wraps (low 16 bits kept).
// ---------------------------------------------------------------------------
module echo_unit #(
  parameter int ADDR_W      = 12,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_sample_in,
  input  logic signed [15:0] sample_in,
  input  logic               enable,
  input  logic               clear,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic               busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W-1:0]   clr_addr_reg;
  logic                acc_reg;       // an accepted strobe is in its mix cycle
  logic                acc_run_reg;   // that strobe was accepted in RUN
  logic                clr_req_reg;   // clear waiting for an in-flight write
  logic signed [15:0]  hold_reg;      // captured sample_in
  logic signed [15:0]  rd_data_reg;   // synchronous read of mem[wr_ptr]
  logic signed [15:0]  sample_out_reg;
  logic                valid_reg;

  logic [15:0] mem [DEPTH];

  logic               accept;
  logic               go_clear;
  logic signed [15:0] delayed_shr;
  logic signed [15:0] mix_out;
  logic signed [15:0] result;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [15:0]        mem_wdata;

  // A strobe right after an accepted one is dropped.
  assign accept = new_sample_in && !acc_reg;

  // Hold off entering CLEAR while a strobe is being accepted, so its feedback
  // write (next cycle) still lands while in RUN.
  assign go_clear = (state_reg == ST_RUN) && (clear || clr_req_reg) && !accept;

  assign delayed_shr = rd_data_reg >>> ATTEN_SHIFT;

`ifdef ECHO_SATURATE_EN
  logic [16:0] mix_wide;
  always_comb begin
    mix_wide = {hold_reg[15], hold_reg} + {delayed_shr[15], delayed_shr};
    if (mix_wide[16] != mix_wide[15])
      mix_out = mix_wide[16] ? 16'sh8000 : 16'sh7fff;
    else
      mix_out = mix_wide[15:0];
  end
`else
  // Low 16 bits of the 17-bit sign-extended sum: a plain 16-bit add.
  assign mix_out = hold_reg + delayed_shr;
`endif

  assign result = (acc_run_reg && enable) ? mix_out : hold_reg;

  // Single write port shared by the clear sweep and the feedback write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_reg;
    mem_wdata = result;
    if (state_reg == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_reg;
      mem_wdata = 16'h0000;
    end else if (acc_reg && acc_run_reg) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    rd_data_reg <= mem[wr_ptr_reg];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_CLEAR;
      wr_ptr_reg     <= '0;
      clr_addr_reg   <= '0;
      acc_reg        <= 1'b0;
      acc_run_reg    <= 1'b0;
      clr_req_reg    <= 1'b0;
      hold_reg       <= '0;
      sample_out_reg <= '0;
      valid_reg      <= 1'b0;
    end else begin
      acc_reg   <= accept;
      valid_reg <= acc_reg;
      if (accept) begin
        hold_reg    <= sample_in;
        acc_run_reg <= (state_reg == ST_RUN);
      end
      if (acc_reg)
        sample_out_reg <= result;

      case (state_reg)
        ST_CLEAR: begin
          clr_req_reg  <= 1'b0;
          clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
          if (clr_addr_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg  <= ST_RUN;
            wr_ptr_reg <= '0;
          end
        end
        default: begin
          if (acc_reg && acc_run_reg)
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
          if (go_clear) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            clr_req_reg  <= 1'b0;
          end else if (clear) begin
            clr_req_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sample_out       = sample_out_reg;
  assign sample_out_valid = valid_reg;
  assign busy             = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_echo_unit.sv
// ---------------------------------------------------------------------------
// tb_echo_unit -- directed bench for echo_unit (ADDR_W=3, ATTEN_SHIFT=1).
// Expected outputs come from a small behavioural echo model and are queued
// with their due cycle; a monitor pops and compares on every valid strobe.
// ---------------------------------------------------------------------------
module tb_echo_unit;

  localparam int AW = 3;
  localparam int D  = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               new_sample_in = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               enable = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               busy;

  echo_unit #(.ADDR_W(AW), .ATTEN_SHIFT(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_in    (new_sample_in),
    .sample_in        (sample_in),
    .enable           (enable),
    .clear            (clear),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int due;} exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   obs_q[$];
  int   last_out = 0;
  int   busy_run = 0;
  int   last_busy_len = 0;
  int   mmem[D];
  int   mptr = 0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int reduce16(input int v);
`ifdef ECHO_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    int w;
    w = v & 32'h0000ffff;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  task automatic model_zero();
    for (int i = 0; i < D; i++) mmem[i] = 0;
    mptr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe, then three idle cycles (strobe period 4).
  task automatic strobe(input int val, input bit pass_mode, input bit with_clear);
    int e;
    if (pass_mode) begin
      e = val;
    end else if (enable) begin
      e = reduce16(val + (mmem[mptr] >>> 1));
      mmem[mptr] = e;
      mptr = (mptr + 1) % D;
    end else begin
      e = val;
      mmem[mptr] = val;
      mptr = (mptr + 1) % D;
    end
    new_sample_in = 1'b1;
    sample_in     = 16'(val);
    clear         = with_clear;
    exp_q.push_back('{e, cyc + 2});
    tick();
    new_sample_in = 1'b0;
    clear         = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_idle(input string tag);
    tick();
    for (int i = 0; i < 40 && busy; i++) tick();
    check({tag, "_busy_timeout"}, int'(busy), 0);
    tick();
    check({tag, "_busy_len"}, last_busy_len, D);
  endtask

  // Clear with two pass-through strobes while busy.
  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    strobe(111, 1'b1, 1'b0);
    strobe(-222, 1'b1, 1'b0);
    wait_idle(tag);
    model_zero();
  endtask

  // Cycle counter and output monitor.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check("rst_out", int'(sample_out), 0);
      check("rst_valid", int'(sample_out_valid), 0);
      check("rst_busy", int'(busy), 1);
      last_out = 0;
      busy_run = 0;
    end else begin
      if (sample_out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_value", int'(sample_out), e.val);
          check("latency", cyc, e.due);
          $display("txn: out=%0d exp=%0d cyc=%0d", sample_out, e.val, cyc);
        end
        obs_q.push_back(int'(sample_out));
      end else begin
        check("hold", int'(sample_out), last_out);
      end
      last_out = int'(sample_out);
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    model_zero();
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    wait_idle("reset");

    // Impulse with feedback decay.
    enable = 1'b1;
    obs_q.delete();
    strobe(1000, 1'b0, 1'b0);
    for (int i = 1; i < 32; i++) strobe(0, 1'b0, 1'b0);
    check("imp_count", obs_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 1000 : (i == 8) ? 500 : (i == 16) ? 250 : (i == 24) ? 125 : 0;
      check($sformatf("imp_s%0d", i), obs_q[i], v);
    end

    // Negative sample: floor shift.
    do_clear("clr1");
    obs_q.delete();
    strobe(-1001, 1'b0, 1'b0);
    for (int i = 1; i < 9; i++) strobe(0, 1'b0, 1'b0);
    check("neg_s8", obs_q[8], -501);

    // Overflow of the mix.
    do_clear("clr2");
    obs_q.delete();
    strobe(30000, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) strobe(0, 1'b0, 1'b0);
    strobe(30000, 1'b0, 1'b0);
`ifdef ECHO_SATURATE_EN
    check("ovf_s8", obs_q[8], 32767);
`else
    check("ovf_s8", obs_q[8], -20536);
`endif

    // Bypass ramp, then a back-to-back strobe pair.
    enable = 1'b0;
    obs_q.delete();
    for (int i = 1; i <= 8; i++) strobe(i, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("ramp_%0d", i), obs_q[i], i + 1);
    new_sample_in = 1'b1;
    sample_in     = 16'sd9;
    mmem[mptr]    = 9;
    mptr          = (mptr + 1) % D;
    exp_q.push_back('{9, cyc + 2});
    tick();
    sample_in = 16'sd77;
    tick();
    new_sample_in = 1'b0;
    repeat (4) tick();
    check("dbl_pulses", obs_q.size(), 9);
    // Echoes of the stored ramp reveal the pointer position.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) strobe(0, 1'b0, 1'b0);

    // Clear together with an accepted strobe, then a clean impulse.
    strobe(55, 1'b0, 1'b1);
    model_zero();
    strobe(333, 1'b1, 1'b0);
    strobe(-444, 1'b1, 1'b0);
    wait_idle("clr3");
    obs_q.delete();
    strobe(1000, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) strobe(0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? 1000 : (i == 8) ? 500 : 0;
      check($sformatf("post_clr_s%0d", i), obs_q[i], v);
    end

    // Reset during an in-flight strobe drops it.
    new_sample_in = 1'b1;
    sample_in     = 16'sd1234;
    tick();
    new_sample_in = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_zero();
    wait_idle("rst2");
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/echo_unit.md
ECHO_UNIT -- requirements
Module: echo_unit

Interface
REQ-001 Parameter ADDR_W, default 12, log2 of the delay-line depth (DEPTH = 2^ADDR_W samples).
REQ-002 Parameter ATTEN_SHIFT, default 1, arithmetic right-shift applied to the delayed sample before mixing.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 new_sample_in  input  1  one-cycle strobe; sample_in is valid this cycle.
REQ-006 sample_in  input  16  signed two's-complement sample from the music player.
REQ-007 enable  input  1  level; 1 = echo mixed in, 0 = bypass.
REQ-008 clear  input  1  one-cycle request to zero the delay line.
REQ-009 sample_out  output  16  signed processed sample, registered.
REQ-010 sample_out_valid  output  1  one-cycle strobe marking a new sample_out.
REQ-011 busy  output  1  high while the delay line is being cleared.

Function
REQ-012 The delay line SHALL be a DEPTH x 16 single-port-write, synchronous-read memory indexed by a wrapping ADDR_W-bit write pointer wr_ptr.
REQ-013 State machine SHALL have two states: CLEAR and RUN; busy = (state == CLEAR).
REQ-014 A strobe is accepted when new_sample_in=1 and no strobe was accepted in the previous cycle; a strobe in the cycle immediately after an accepted one SHALL be ignored, with no write and no pointer advance.
REQ-015 Accepted strobe at cycle T: the memory SHALL be read at wr_ptr in T and sample_in captured; in T+1 delayed = read data and the mix is computed.
REQ-016 The mix SHALL be sample_in + (delayed >>> ATTEN_SHIFT), computed 17 bits wide with sign extension.
REQ-017 In RUN with enable=1: sample_out SHALL be the mix (width-reduced per REQ-027/028), and the same value SHALL be written to mem[wr_ptr] at the end of T+1 (feedback echo).
REQ-018 In RUN with enable=0: sample_out SHALL equal sample_in, and sample_in SHALL be written to mem[wr_ptr].
REQ-019 wr_ptr SHALL increment by 1 at the end of T+1 in RUN, wrapping from DEPTH-1 to 0.
REQ-020 sample_out and sample_out_valid SHALL update at the end of T+1, so sample_out_valid is high in cycle T+2 (latency 2), for exactly one cycle per accepted strobe.
REQ-021 sample_out SHALL hold its last value between strobes.
REQ-022 clear in RUN SHALL enter CLEAR after any in-flight strobe's write completes; clear arriving during CLEAR SHALL be ignored.
REQ-023 In CLEAR the block SHALL write 0 to addresses 0..DEPTH-1, one per cycle, then set wr_ptr=0 and enter RUN; CLEAR lasts exactly DEPTH cycles.
REQ-024 Strobes during CLEAR SHALL still be accepted, producing sample_out = sample_in with latency 2, with no memory write and no wr_ptr change.

Reset
REQ-025 While reset=0: sample_out=0, sample_out_valid=0, wr_ptr=0, pipeline empty, state=CLEAR with clear address 0.
REQ-026 After reset deasserts, busy SHALL stay high for DEPTH cycles while the memory is zeroed; reset mid-clear or mid-strobe SHALL abort the operation, drop the in-flight sample, and restart clearing from address 0.

Configuration
REQ-027 With ECHO_SATURATE_EN defined: the 17-bit mix SHALL be clamped to [-32768, 32767] for both sample_out and the feedback write.
REQ-028 Without ECHO_SATURATE_EN: the mix SHALL be truncated to its low 16 bits (two's-complement wrap) for both.

Verification (ADDR_W=3, ATTEN_SHIFT=1, strobes every 4 cycles)
REQ-029 Release reset -> busy=1 for exactly 8 cycles then 0; sample_out=0, sample_out_valid=0 throughout.
REQ-030 enable=1, impulse 1000 at strobe 0, then zeros -> sample_out = 1000 at strobe 0, 500 at 8, 250 at 16, 125 at 24, and 0 otherwise; valid 2 cycles after each strobe.
REQ-031 sample_in -1001 at strobe 0, then zeros -> sample_out = -501 at strobe 8 (arithmetic floor shift).
REQ-032 30000 at strobes 0 and 8 -> strobe-8 output = 32767 with ECHO_SATURATE_EN, or -20536 without.
REQ-033 enable=0, ramp 1,2,3... -> sample_out equals sample_in exactly, latency 2; strobes on two consecutive cycles -> one valid pulse and wr_ptr advances by 1.
REQ-034 clear pulse mid-stream -> busy high for 8 cycles, pass-through outputs during busy, then impulse 1000 -> no residual echo other than 500 at +8 strobes.
